// File: rtl/soc_cfg_pkg.sv
// Shared definitions for the SoC configuration register block: register
// offsets, the bus FSM state type and the per-CPU slot ceiling.
package soc_cfg_pkg;

   localparam int CPU_MAX_LIMIT = 8;

   localparam logic [9:0] OFF_HW_ID     = 10'h000;
   localparam logic [9:0] OFF_CPU       = 10'h004;
   localparam logic [9:0] OFF_ICACHE    = 10'h008;
   localparam logic [9:0] OFF_DCACHE    = 10'h00C;
   localparam logic [9:0] OFF_L2        = 10'h010;
   localparam logic [9:0] OFF_MEM       = 10'h014;
   localparam logic [9:0] OFF_UART      = 10'h018;
   localparam logic [9:0] OFF_LOCK      = 10'h01C;
   localparam logic [9:0] OFF_UPTIME_LO = 10'h020;
   localparam logic [9:0] OFF_UPTIME_HI = 10'h024;
   localparam logic [9:0] OFF_BOOT0     = 10'h040;
   localparam logic [9:0] OFF_HALT      = 10'h080;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      RESP
   } state_t;

   // Cache-style geometry word: {nways[15:8], lines[7:0]}
   function automatic logic [31:0] pack_geom(input int nways, input int lines);
      return {16'h0000, 8'(nways), 8'(lines)};
   endfunction

endpackage

// File: rtl/soc_cfg_if.sv
// APB3 bus bundle between a master and the configuration register slave.
interface soc_cfg_if;

   logic        i_psel;
   logic        i_penable;
   logic        i_pwrite;
   logic [9:0]  i_paddr;
   logic [31:0] i_pwdata;
   logic        o_pready;
   logic [31:0] o_prdata;
   logic        o_pslverr;

   modport master (
      output i_psel, i_penable, i_pwrite, i_paddr, i_pwdata,
      input  o_pready, o_prdata, o_pslverr
   );

   modport slave (
      input  i_psel, i_penable, i_pwrite, i_paddr, i_pwdata,
      output o_pready, o_prdata, o_pslverr
   );

endinterface

// File: rtl/soc_cfg_uptime.sv
// 64-bit free-running uptime counter with an upper-half shadow captured when
// the lower half is read, so firmware sees a coherent 64-bit value.
module soc_cfg_uptime (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        snap,
   output logic [31:0] count_lo,
   output logic [31:0] shadow
);

   logic [63:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count  <= '0;
         shadow <= '0;
      end else begin
         count <= count + 64'd1;
         if (snap) shadow <= count[63:32];
      end
   end

   assign count_lo = count[31:0];

endmodule

// File: rtl/soc_cfg_regs.sv
// APB3 SoC configuration/identification registers with boot vectors, halt
// mask and a sticky lock. Optional uptime counter under SOC_CFG_UPTIME_EN.
module soc_cfg_regs
   import soc_cfg_pkg::*;
#(
   parameter int          CPU_MAX           = 4,
   parameter int          WAIT_CYCLES       = 0,
   parameter logic [31:0] HW_ID             = 32'h2022_1101,
   parameter int          CPU_NUM           = 1,
   parameter int          ILOG2_LINES       = 7,
   parameter int          ILOG2_NWAYS       = 2,
   parameter int          DLOG2_LINES       = 7,
   parameter int          DLOG2_NWAYS       = 2,
   parameter int          L2_ENA            = 0,
   parameter int          L2_LOG2_LINES     = 9,
   parameter int          L2_LOG2_NWAYS     = 4,
   parameter int          BOOTROM_LOG2      = 16,
   parameter int          SRAM_LOG2         = 18,
   parameter int          UART_SPEEDUP      = 0,
   parameter logic [31:0] BOOT_ADDR_DEFAULT = 32'h0001_0000
) (
   input  logic                   i_clk,
   input  logic                   i_nrst,
   soc_cfg_if.slave               apb,
   output logic [CPU_MAX*32-1:0]  o_boot_addr,
   output logic [CPU_MAX-1:0]     o_halt,
   output logic                   o_locked
);

   localparam logic [2:0]         WAIT_LAST  = 3'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
   localparam logic [CPU_MAX-1:0] HALT_RESET = ~CPU_MAX'(1);

   state_t               state, state_nxt;
   logic [2:0]           wait_cnt, wait_cnt_nxt;
   logic                 resp_load;
   logic [31:0]          boot_q [CPU_MAX];
   logic [CPU_MAX-1:0]   halt_q;
   logic                 locked_q;
   logic [9:0]           off;
   logic [31:0]          rd_val, rd_data;
   logic                 mapped, writable, guarded, err, commit;
   logic [CPU_MAX-1:0]   boot_hit;
   logic [31:0]          uptime_lo, uptime_hi;
   logic                 pready_q, pslverr_q;
   logic [31:0]          prdata_q;
   logic                 unused_addr_bits;

   assign unused_addr_bits = ^apb.i_paddr[1:0];

`ifdef SOC_CFG_UPTIME_EN
   logic uptime_snap;

   assign uptime_snap = resp_load && !apb.i_pwrite && (off == OFF_UPTIME_LO);

   soc_cfg_uptime u_uptime (
      .clk      (i_clk),
      .rst_n    (i_nrst),
      .snap     (uptime_snap),
      .count_lo (uptime_lo),
      .shadow   (uptime_hi)
   );
`else
   assign uptime_lo = '0;
   assign uptime_hi = '0;
`endif

   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         state    <= IDLE;
         wait_cnt <= '0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_cnt_nxt;
      end
   end

   // With no wait states the access phase is empty, so setup goes straight to RESP
   // and o_pready lands in the first penable cycle.
   always_comb begin
      state_nxt    = state;
      wait_cnt_nxt = wait_cnt;
      case (state)
         IDLE: begin
            if (apb.i_psel && !apb.i_penable) begin
               wait_cnt_nxt = '0;
               state_nxt    = (WAIT_CYCLES == 0) ? RESP : ACCESS;
            end
         end
         ACCESS: begin
            if (!apb.i_psel)                state_nxt = IDLE;
            else if (wait_cnt == WAIT_LAST) state_nxt = RESP;
            else                            wait_cnt_nxt = wait_cnt + 3'd1;
         end
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      resp_load = (state != RESP) && (state_nxt == RESP);
   end

   always_comb begin
      off      = {apb.i_paddr[9:2], 2'b00};
      rd_val   = '0;
      mapped   = 1'b1;
      writable = 1'b0;
      guarded  = 1'b0;
      boot_hit = '0;
      case (off)
         OFF_HW_ID:     rd_val = HW_ID;
         OFF_CPU:       rd_val = {23'h0, 1'(L2_ENA), 8'(CPU_NUM)};
         OFF_ICACHE:    rd_val = pack_geom(ILOG2_NWAYS, ILOG2_LINES);
         OFF_DCACHE:    rd_val = pack_geom(DLOG2_NWAYS, DLOG2_LINES);
         OFF_L2:        rd_val = pack_geom(L2_LOG2_NWAYS, L2_LOG2_LINES);
         OFF_MEM:       rd_val = pack_geom(SRAM_LOG2, BOOTROM_LOG2);
         OFF_UART:      rd_val = 32'(UART_SPEEDUP);
         OFF_UPTIME_LO: rd_val = uptime_lo;
         OFF_UPTIME_HI: rd_val = uptime_hi;
         OFF_LOCK: begin
            rd_val   = {31'h0, locked_q};
            writable = 1'b1;
         end
         OFF_HALT: begin
            rd_val   = 32'(halt_q);
            writable = 1'b1;
            guarded  = 1'b1;
         end
         default: begin
            mapped = 1'b0;
            for (int n = 0; n < CPU_MAX; n++) begin
               if (off == OFF_BOOT0 + 10'(4 * n)) begin
                  rd_val      = boot_q[n];
                  boot_hit[n] = 1'b1;
                  mapped      = 1'b1;
                  writable    = 1'b1;
                  guarded     = 1'b1;
               end
            end
         end
      endcase
      err     = !mapped || (apb.i_pwrite && (!writable || (guarded && locked_q)));
      rd_data = (apb.i_pwrite || err) ? '0 : rd_val;
      commit  = (state == RESP) && apb.i_psel && apb.i_pwrite && !err;
   end

   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         pready_q  <= 1'b0;
         prdata_q  <= '0;
         pslverr_q <= 1'b0;
      end else begin
         pready_q  <= resp_load;
         prdata_q  <= resp_load ? rd_data : '0;
         pslverr_q <= resp_load && err;
      end
   end

   // Bus values are held stable through the response cycle, so the write
   // decode is re-evaluated there rather than stored at the start of the access.
   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         for (int n = 0; n < CPU_MAX; n++) boot_q[n] <= BOOT_ADDR_DEFAULT;
         halt_q   <= HALT_RESET;
         locked_q <= 1'b0;
      end else if (commit) begin
         if (off == OFF_LOCK && apb.i_pwdata[0]) locked_q <= 1'b1;
         if (off == OFF_HALT) halt_q <= apb.i_pwdata[CPU_MAX-1:0];
         for (int n = 0; n < CPU_MAX; n++) begin
            if (boot_hit[n]) boot_q[n] <= {apb.i_pwdata[31:2], 2'b00};
         end
      end
   end

   always_comb begin
      o_boot_addr = '0;
      for (int n = 0; n < CPU_MAX; n++) o_boot_addr[32*n +: 32] = boot_q[n];
   end

   assign o_halt        = halt_q;
   assign o_locked      = locked_q;
   assign apb.o_pready  = pready_q;
   assign apb.o_prdata  = prdata_q;
   assign apb.o_pslverr = pslverr_q;

endmodule

// File: tb/tb_soc_cfg_regs.sv
// Randomized bench for soc_cfg_regs: two instances (0 and 3 wait states) share
// one APB master and are compared against a register-map reference model.
module tb_soc_cfg_regs;

   localparam int CPU = 4;

   logic clk = 1'b0;
   logic rst_n;
   logic psel0, psel3, penable, pwrite;
   logic [9:0]  paddr;
   logic [31:0] pwdata;

   always #5 clk = ~clk;

   soc_cfg_if bus0 ();
   soc_cfg_if bus3 ();

   assign bus0.i_psel    = psel0;
   assign bus0.i_penable = penable;
   assign bus0.i_pwrite  = pwrite;
   assign bus0.i_paddr   = paddr;
   assign bus0.i_pwdata  = pwdata;
   assign bus3.i_psel    = psel3;
   assign bus3.i_penable = penable;
   assign bus3.i_pwrite  = pwrite;
   assign bus3.i_paddr   = paddr;
   assign bus3.i_pwdata  = pwdata;

   logic [CPU*32-1:0] boot0, boot3;
   logic [CPU-1:0]    halt0, halt3;
   logic              locked0, locked3;

   soc_cfg_regs #(.CPU_MAX(CPU), .WAIT_CYCLES(0)) dut0 (
      .i_clk(clk), .i_nrst(rst_n), .apb(bus0),
      .o_boot_addr(boot0), .o_halt(halt0), .o_locked(locked0)
   );

   soc_cfg_regs #(.CPU_MAX(CPU), .WAIT_CYCLES(3)) dut3 (
      .i_clk(clk), .i_nrst(rst_n), .apb(bus3),
      .o_boot_addr(boot3), .o_halt(halt3), .o_locked(locked3)
   );

   int check_count = 0;
   int pass_count  = 0;

   logic [31:0]    m_boot [CPU];
   logic [CPU-1:0] m_halt;
   bit             m_locked;
   logic [31:0]    ro_tbl [10] = '{32'h2022_1101, 32'h0000_0001, 32'h0000_0207, 32'h0000_0207,
                                   32'h0000_0409, 32'h0000_1210, 32'h0, 32'h0, 32'h0, 32'h0};
   int             addr_pool [16] = '{'h00, 'h04, 'h08, 'h0C, 'h10, 'h14, 'h18, 'h28,
                                      'h3C, 'h40, 'h44, 'h48, 'h4C, 'h50, 'h80, 'h84};

   task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
      check_count++;
      if (actual === expected) pass_count++;
      else $display("[TB] FAIL %s: actual %0h required %0h", tag, actual, expected);
   endtask

   function automatic void model_reset();
      for (int n = 0; n < CPU; n++) m_boot[n] = 32'h0001_0000;
      m_halt   = 4'b1110;
      m_locked = 1'b0;
   endfunction

   function automatic void model_access(input bit wr, input int addr, input logic [31:0] wd,
                                        output logic [31:0] rd, output bit err);
      int a = addr & 'h3FC;
      rd  = '0;
      err = 1'b0;
      if (a == 'h1C) begin
         if (wr) begin
            if (wd[0]) m_locked = 1'b1;
         end else rd = {31'h0, m_locked};
      end else if (a >= 'h40 && a < 'h40 + 4 * CPU) begin
         if (!wr) rd = m_boot[(a - 'h40) / 4];
         else if (m_locked) err = 1'b1;
         else m_boot[(a - 'h40) / 4] = wd & 32'hFFFF_FFFC;
      end else if (a == 'h80) begin
         if (!wr) rd = 32'(m_halt);
         else if (m_locked) err = 1'b1;
         else m_halt = wd[CPU-1:0];
      end else if (a <= 'h24) begin
         if (wr) err = 1'b1;
         else rd = ro_tbl[a / 4];
      end else err = 1'b1;
   endfunction

   function automatic logic [CPU*32-1:0] model_boot_flat();
      logic [CPU*32-1:0] v;
      for (int n = 0; n < CPU; n++) v[32*n +: 32] = m_boot[n];
      return v;
   endfunction

   task automatic applyStimulus(input bit wr, input logic [9:0] addr, input logic [31:0] wd,
                                output logic [31:0] rd0, output bit err0, output int lat0,
                                output logic [31:0] rd3, output bit err3, output int lat3);
      lat0 = 0; lat3 = 0; rd0 = '0; rd3 = '0; err0 = 1'b0; err3 = 1'b0;
      @(negedge clk);
      psel0 = 1'b1; psel3 = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd;
      @(negedge clk);
      penable = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         if (lat0 == 0 && bus0.o_pready) begin
            lat0 = k; rd0 = bus0.o_prdata; err0 = bus0.o_pslverr;
         end
         if (lat3 == 0 && bus3.o_pready) begin
            lat3 = k; rd3 = bus3.o_prdata; err3 = bus3.o_pslverr;
         end
         if (lat0 != 0 && lat3 != 0) break;
         @(negedge clk);
      end
      @(negedge clk);
      psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0; pwrite = 1'b0;
   endtask

   task automatic do_transaction(input string tag, input bit wr, input logic [9:0] addr, input logic [31:0] wd);
      logic [31:0] rd0, rd3, exp_rd;
      bit          err0, err3, exp_err;
      int          lat0, lat3;
      applyStimulus(wr, addr, wd, rd0, err0, lat0, rd3, err3, lat3);
      model_access(wr, int'(addr), wd, exp_rd, exp_err);
      checkOutput({tag, "_lat0"}, lat0, 1);
      checkOutput({tag, "_lat3"}, lat3, 4);
      checkOutput({tag, "_rd0"}, rd0, exp_rd);
      checkOutput({tag, "_rd3"}, rd3, exp_rd);
      checkOutput({tag, "_err0"}, err0, exp_err);
      checkOutput({tag, "_err3"}, err3, exp_err);
      checkOutput({tag, "_boot0"}, boot0, model_boot_flat());
      checkOutput({tag, "_boot3"}, boot3, model_boot_flat());
      checkOutput({tag, "_halt0"}, halt0, m_halt);
      checkOutput({tag, "_halt3"}, halt3, m_halt);
      checkOutput({tag, "_lock0"}, locked0, m_locked);
      checkOutput({tag, "_lock3"}, locked3, m_locked);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic check_idle_outputs(input string tag);
      checkOutput({tag, "_pready"}, {bus0.o_pready, bus3.o_pready}, 2'b00);
      checkOutput({tag, "_prdata"}, {bus0.o_prdata, bus3.o_prdata}, 64'h0);
      checkOutput({tag, "_pslverr"}, {bus0.o_pslverr, bus3.o_pslverr}, 2'b00);
      checkOutput({tag, "_boot0"}, boot0, model_boot_flat());
      checkOutput({tag, "_boot3"}, boot3, model_boot_flat());
      checkOutput({tag, "_halt"}, {halt0, halt3}, {m_halt, m_halt});
      checkOutput({tag, "_locked"}, {locked0, locked3}, 2'b00);
   endtask

   task automatic applyAbort(input logic [9:0] addr, input logic [31:0] wd);
      int seen = 0;
      @(negedge clk);
      psel3 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = addr; pwdata = wd;
      @(negedge clk);
      penable = 1'b1;
      if (bus3.o_pready) seen++;
      @(negedge clk);
      if (bus3.o_pready) seen++;
      psel3 = 1'b0; penable = 1'b0; pwrite = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (bus3.o_pready) seen++;
      end
      checkOutput("abort_no_pready", seen, 0);
      checkOutput("abort_boot3", boot3, model_boot_flat());
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: actual timeout required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [31:0] a_rd0, a_rd3, b_rd0, b_rd3, c_rd0, c_rd3;
      bit          a_e0, a_e3, b_e0, b_e3, c_e0, c_e3;
      int          a_l0, a_l3, b_l0, b_l3, c_l0, c_l3;

      psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      check_idle_outputs("reset");

      do_transaction("hwid", 1'b0, 10'h000, 32'h0);
      do_transaction("icache", 1'b0, 10'h008, 32'h0);
      do_transaction("boot1_wr", 1'b1, 10'h044, 32'h8000_0003);
      do_transaction("halt_wr", 1'b1, 10'h080, 32'h0);
      do_transaction("ro_wr", 1'b1, 10'h000, 32'hFFFF_FFFF);
      do_transaction("unmapped_rd", 1'b0, 10'h03C, 32'h0);
      do_transaction("lock_zero", 1'b1, 10'h01C, 32'h0);

`ifdef SOC_CFG_UPTIME_EN
      applyStimulus(1'b0, 10'h020, 32'h0, a_rd0, a_e0, a_l0, a_rd3, a_e3, a_l3);
      applyStimulus(1'b0, 10'h024, 32'h0, b_rd0, b_e0, b_l0, b_rd3, b_e3, b_l3);
      applyStimulus(1'b0, 10'h020, 32'h0, c_rd0, c_e0, c_l0, c_rd3, c_e3, c_l3);
      checkOutput("uptime_err", {a_e0, a_e3, b_e0, b_e3}, 4'b0000);
      checkOutput("uptime_hi", {b_rd0, b_rd3}, 64'h0);
      checkOutput("uptime_advances", (c_rd0 > a_rd0) && (c_rd3 > a_rd3), 1'b1);
      checkOutput("uptime_lat", {a_l0, a_l3}, {32'd1, 32'd4});
`else
      do_transaction("uptime_lo", 1'b0, 10'h020, 32'h0);
      do_transaction("uptime_hi", 1'b0, 10'h024, 32'h0);
`endif

      for (int i = 0; i < 80; i++) begin
         int          a;
         logic [31:0] d;
         bit          wr;
         if ($urandom_range(0, 4) == 0) a = int'($urandom_range(33, 255)) * 4;
         else a = addr_pool[$urandom_range(0, 15)];
         a  = a | int'($urandom_range(0, 3));
         d  = $urandom;
         wr = 1'($urandom_range(0, 1));
         do_transaction($sformatf("rand%0d", i), wr, 10'(a), d);
      end

      applyAbort(10'h048, 32'hDEAD_BEEC);

      @(negedge clk);
      psel3 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 10'h04C; pwdata = 32'hCAFE_0000;
      @(negedge clk);
      penable = 1'b1;
      @(negedge clk);
      rst_n = 1'b0;
      psel3 = 1'b0; penable = 1'b0; pwrite = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      check_idle_outputs("midreset");

      do_transaction("lock_set", 1'b1, 10'h01C, 32'h1);
      do_transaction("locked_boot0", 1'b1, 10'h040, 32'h0000_1234);
      do_transaction("locked_halt", 1'b1, 10'h080, 32'hF);
      do_transaction("locked_rd", 1'b0, 10'h040, 32'h0);
      checkOutput("lock_set_boot0", boot0[31:0], 32'h0001_0000);

      do_reset();
      check_idle_outputs("unlock");

      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule

// File: doc/soc_cfg_regs.md
SOC_CFG_REGS -- requirements
Module: soc_cfg_regs

Interface
REQ-001 SHALL have parameter CPU_MAX, default 4, number of per-CPU boot/halt slots (legal 1..8).
REQ-002 SHALL have parameter WAIT_CYCLES, default 0, APB wait states inserted per access (legal 0..7).
REQ-003 SHALL have parameter HW_ID, default 32'h20221101, read-only platform identifier.
REQ-004 SHALL have parameters CPU_NUM, ILOG2_LINES, ILOG2_NWAYS, DLOG2_LINES, DLOG2_NWAYS, L2_ENA, L2_LOG2_LINES, L2_LOG2_NWAYS, BOOTROM_LOG2, SRAM_LOG2, UART_SPEEDUP, defaults 1,7,2,7,2,0,9,4,16,18,0: SoC geometry published to firmware.
REQ-005 SHALL have parameter BOOT_ADDR_DEFAULT, default 32'h0001_0000, reset value of every boot-address register.
REQ-006 i_clk  in  1  single clock, all state on rising edge.
REQ-007 i_nrst  in  1  reset, asynchronous, active-low.
REQ-008 i_psel, i_penable, i_pwrite  in  1 each  APB3 control.
REQ-009 i_paddr  in  10  byte address, bits [1:0] ignored; i_pwdata  in  32  write data.
REQ-010 o_pready  out  1; o_prdata  out  32; o_pslverr  out  1  APB3 response.
REQ-011 o_boot_addr  out  CPU_MAX*32  per-CPU reset vector, slot n at [32n+31:32n].
REQ-012 o_halt  out  CPU_MAX  per-CPU hold-in-reset request; o_locked  out  1  lock state.

Function
REQ-013 Map: 0x00 HW_ID; 0x04 {L2_ENA[8],CPU_NUM[7:0]}; 0x08 I$ {nways[15:8],lines[7:0]}; 0x0C D$ same; 0x10 L2 same; 0x14 {SRAM_LOG2[15:8],BOOTROM_LOG2[7:0]}; 0x18 UART_SPEEDUP; 0x1C LOCK; 0x20 UPTIME_LO; 0x24 UPTIME_HI; 0x40+4n BOOTADDR[n] for n<CPU_MAX; 0x80 HALT mask [CPU_MAX-1:0]. Unused bits read 0.
REQ-014 FSM states IDLE, ACCESS, RESP; IDLE->ACCESS on i_psel&!i_penable; ACCESS counts WAIT_CYCLES then ->RESP; RESP drives o_pready=1 for exactly one cycle, then ->IDLE.
REQ-015 Latency: setup cycle + WAIT_CYCLES+1 access cycles; WAIT_CYCLES=0 gives o_pready in first penable cycle.
REQ-016 o_prdata and o_pslverr are registered, valid only while o_pready=1, 0 otherwise.
REQ-017 i_psel deasserted in ACCESS aborts to IDLE without register update or o_pready.
REQ-018 Writes commit in the o_pready cycle; read-only offsets and unmapped offsets return o_pslverr=1, prdata 0, no state change.
REQ-019 LOCK write with pwdata[0]=1 sets lock, sticky until reset; writing 0 is ignored, no error.
REQ-020 While locked, writes to BOOTADDR/HALT return o_pslverr=1 and do not update; reads unaffected.
REQ-021 BOOTADDR writes force bits [1:0] to 0.
REQ-022 Reading UPTIME_LO snapshots the upper 32 bits into a shadow; UPTIME_HI returns the shadow (coherent 64-bit read).

Reset
REQ-023 On i_nrst=0: FSM IDLE, o_pready/o_pslverr/o_prdata=0, o_boot_addr all BOOT_ADDR_DEFAULT, o_halt={CPU_MAX{1'b1}} except bit0=0, o_locked=0, uptime and shadow 0.
REQ-024 Reset mid-transaction discards the transaction; no partial write persists.

Configuration
REQ-025 Macro SOC_CFG_UPTIME_EN defined: 64-bit free-running cycle counter, +1 every cycle, wraps at 2^64-1 to 0.
REQ-026 Macro undefined: no counter logic; UPTIME_LO/HI read 0 with o_pslverr=0.

Structure
REQ-027 Shared package soc_cfg_pkg SHALL hold register offset constants, the FSM state typedef and the CPU_MAX upper bound 8.
REQ-028 Counter and shadow SHALL be sub-module soc_cfg_uptime, instantiated only under SOC_CFG_UPTIME_EN.

Verification
REQ-029 Read 0x00 after reset, WAIT_CYCLES=0 -> o_prdata=32'h20221101, o_pslverr=0, o_pready in first penable cycle.
REQ-030 WAIT_CYCLES=3, read 0x08 -> o_pready on 4th penable cycle, o_prdata=32'h0000_0207.
REQ-031 Write 0x44<=32'h8000_0003 -> o_boot_addr slot1=32'h8000_0000; write 0x80<=0 -> o_halt=0.
REQ-032 Write 0x1C<=1 then 0x40<=32'h1234 -> o_pslverr=1, slot0 stays 32'h0001_0000, o_locked=1; assert i_nrst -> o_locked=0.
REQ-033 Write 0x00 and read 0x3C -> o_pslverr=1, o_prdata=0 both.
REQ-034 With SOC_CFG_UPTIME_EN, counter preloaded to 64'hFFFF_FFFF: read LO then HI -> HI equals value at LO-read instant despite carry; without macro both read 0.
